// File: rtl/raptor64_pkg.sv
// raptor64_pkg: shared widths, iteration count, multiplier states and magnitude helper
package raptor64_pkg;
  localparam int WID = 64;
  localparam int ITERS = WID;
  localparam int CW = $clog2(ITERS + 1);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  function automatic logic [WID-1:0] mag(input logic [WID-1:0] x, input logic s);
    return (s && x[WID-1]) ? -x : x;
  endfunction
endpackage

// File: rtl/raptor64_mult_step.sv
// raptor64_mult_step: one radix-2 shift-add iteration on the 129-bit accumulator
module raptor64_mult_step
  import raptor64_pkg::*;
(
  input  logic [2*WID:0] acc_i,
  input  logic [WID-1:0] mcand_i,
  output logic [2*WID:0] acc_o
);
  logic [WID:0] hi;
  // add the multiplicand into the upper half when the low bit is set, then shift right
  always_comb begin
    hi = acc_i[0] ? acc_i[2*WID:WID] + {1'b0, mcand_i} : acc_i[2*WID:WID];
    acc_o = {1'b0, hi, acc_i[WID-1:1]};
  end
endmodule

// File: rtl/raptor64_mult.sv
// raptor64_mult: iterative 64x64 signed/unsigned multiplier with ld/done handshake
module raptor64_mult
  import raptor64_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           ld,
  input  logic           sgn,
  input  logic           isMuli,
  input  logic [WID-1:0] a,
  input  logic [WID-1:0] b,
  input  logic [WID-1:0] imm,
  output logic [WID-1:0] prodLo,
  output logic [WID-1:0] prodHi,
  output logic           ovf,
  output logic           done
);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WID:0] acc_q, acc_d, acc_nx;
  logic [WID-1:0] mcand_q, mcand_d, lo_q, lo_d, hi_q, hi_d, op2;
  logic so_q, so_d, sgn_q, sgn_d, ovf_q, ovf_d;
  logic [2*WID-1:0] p;
  raptor64_mult_step u_step (
    .acc_i  (acc_q),
    .mcand_i(mcand_q),
    .acc_o  (acc_nx)
  );
  // next-state, operand capture, iteration and sign fix-up
  always_comb begin
    op2 = isMuli ? imm : b;
    p = so_q ? -acc_q[2*WID-1:0] : acc_q[2*WID-1:0];
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    mcand_d = mcand_q;
    so_d = so_q;
    sgn_d = sgn_q;
    lo_d = lo_q;
    hi_d = hi_q;
    ovf_d = ovf_q;
    if (state_q == IDLE && ld) begin
      state_d = MUL;
      mcand_d = mag(a, sgn);
      acc_d = {{(WID+1){1'b0}}, mag(op2, sgn)};
      so_d = sgn & (a[WID-1] ^ op2[WID-1]);
      sgn_d = sgn;
      cnt_d = CW'(ITERS);
    end else if (state_q == MUL && cnt_q != '0) begin
      acc_d = acc_nx;
      cnt_d = cnt_q - 1'b1;
    end else if (state_q == MUL) begin
      state_d = DONE;
      lo_d = p[WID-1:0];
      hi_d = p[2*WID-1:WID];
      ovf_d = sgn_q ? !(&p[2*WID-1:WID-1] || ~|p[2*WID-1:WID-1]) : |p[2*WID-1:WID];
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      mcand_q <= '0;
      so_q <= 1'b0;
      sgn_q <= 1'b0;
      lo_q <= '0;
      hi_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      so_q <= so_d;
      sgn_q <= sgn_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      ovf_q <= ovf_d;
    end
  end
  assign prodLo = lo_q;
  assign prodHi = hi_q;
  assign ovf = ovf_q;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_raptor64_mult.sv
// tb_raptor64_mult: table-driven and scoreboard checks of the iterative multiplier
module tb_raptor64_mult;
  typedef struct {
    logic s, im;
    logic [63:0] a, b, imm, lo, hi;
    logic ovf;
  } vec_t;
  typedef struct {
    logic [63:0] lo, hi;
    logic ovf;
    int e0;
    string nm;
  } exp_t;
  logic clk = 0, rst = 1, ld = 0, sgn = 0, isMuli = 0;
  logic [63:0] a = '0, b = '0, imm = '0, prodLo, prodHi;
  logic ovf, done;
  int total = 0, bad = 0, cyc = 0, done_cnt = 0;
  exp_t q[$];
  vec_t tbl[13];
  raptor64_mult dut (
    .clk(clk), .rst(rst), .ld(ld), .sgn(sgn), .isMuli(isMuli),
    .a(a), .b(b), .imm(imm),
    .prodLo(prodLo), .prodHi(prodHi), .ovf(ovf), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic s, input logic im, input logic [63:0] a_, input logic [63:0] b_, input logic [63:0] i_);
    vec_t v;
    logic [63:0] o;
    logic [127:0] p;
    o = im ? i_ : b_;
    if (s) p = $signed({{64{a_[63]}}, a_}) * $signed({{64{o[63]}}, o});
    else p = {64'b0, a_} * {64'b0, o};
    v.s = s; v.im = im; v.a = a_; v.b = b_; v.imm = i_;
    v.lo = p[63:0]; v.hi = p[127:64];
    v.ovf = s ? !(&p[127:63] || ~|p[127:63]) : |p[127:64];
    return v;
  endfunction
  always @(negedge clk) if (rst && done) begin
    exp_t e;
    done_cnt++;
    if (q.size() == 0) chk("spurious_done", 1, 0);
    else begin
      e = q.pop_front();
      chk($sformatf("%s_latency", e.nm), 128'(cyc - e.e0), 128'd65);
      chk($sformatf("%s_lo", e.nm), {64'b0, prodLo}, {64'b0, e.lo});
      chk($sformatf("%s_hi", e.nm), {64'b0, prodHi}, {64'b0, e.hi});
      chk($sformatf("%s_ovf", e.nm), {127'b0, ovf}, {127'b0, e.ovf});
    end
  end
  task automatic drive(input vec_t v);
    sgn = v.s; isMuli = v.im; a = v.a; b = v.b; imm = v.imm; ld = 1;
  endtask
  task automatic wait_empty(input string nm);
    for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
    chk({nm, "_timeout"}, 128'(q.size()), 0);
    q.delete();
  endtask
  task automatic run_op(input vec_t v, input string nm);
    @(posedge clk); #1;
    drive(v);
    @(posedge clk); #1;
    ld = 0;
    q.push_back('{v.lo, v.hi, v.ovf, cyc, nm});
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; imm = {$urandom, $urandom};
    sgn = ~sgn; isMuli = ~isMuli;
    wait_empty(nm);
  endtask
  initial begin
    int e0, dc;
    tbl[0]  = '{1'b0, 1'b0, 64'd10005, 64'd27, 64'd0, 64'd270135, 64'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFEB, '1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, '1, '1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, '1, '1, 64'd0, 64'd1, 64'd0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 64'd0, 64'h4000_0000_0000_0000, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 64'd123, 64'd5, 64'd1000, 64'd123000, 64'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 64'd0, 64'd1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, '1, 64'd0, 64'h8000_0000_0000_0001, '1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 64'h8000_0000_0000_0000, '1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 64'h8000_0000_0000_0000, 64'd0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 64'd0, 64'hDEAD_BEEF_1234_5678, 64'd0, 64'd0, 64'd0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd99, 64'hFFFF_FFFF_FFFF_FFFA, 64'd30, 64'd0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 64'h1_0000_0000, 64'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFF_0000_0000, 64'd0, 1'b0};
    #3 rst = 0;
    #1;
    chk("reset_lo", {64'b0, prodLo}, 0);
    chk("reset_hi", {64'b0, prodHi}, 0);
    chk("reset_ovf", {127'b0, ovf}, 0);
    chk("reset_done", {127'b0, done}, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    for (int i = 0; i < 13; i++) run_op(tbl[i], $sformatf("v%0d", i));
    for (int i = 0; i < 6; i++)
      run_op(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}), $sformatf("rnd%0d", i));
    @(posedge clk); #1;
    drive(tbl[5]);
    @(posedge clk); #1;
    e0 = cyc;
    q.push_back('{tbl[5].lo, tbl[5].hi, tbl[5].ovf, e0, "held1"});
    q.push_back('{tbl[5].lo, tbl[5].hi, tbl[5].ovf, e0 + 67, "held2"});
    repeat (67) @(posedge clk);
    #1 ld = 0;
    wait_empty("held");
    @(posedge clk); #1;
    drive(mk(1'b0, 1'b0, 64'd5, 64'd6, 64'd0));
    @(posedge clk); #1;
    ld = 0;
    repeat (30) @(posedge clk);
    #2 rst = 0;
    #1;
    dc = done_cnt;
    chk("abort_lo", {64'b0, prodLo}, 0);
    chk("abort_hi", {64'b0, prodHi}, 0);
    chk("abort_ovf", {127'b0, ovf}, 0);
    chk("abort_done", {127'b0, done}, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (80) @(posedge clk);
    chk("abort_no_done", 128'(done_cnt - dc), 0);
    run_op(tbl[0], "after_reset");
    run_op(tbl[4], "after_reset2");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/raptor64_mult.md
# raptor64_mult

Iterative 64×64 multiplier for the Raptor64 execute stage; the multiply-side counterpart of the divider, sharing its `ld`/`done` handshake and register-vs-immediate operand selection. It accepts one operation in IDLE, runs a radix-2 shift-add loop for 64 cycles, and presents a registered 128-bit product. It supports signed and unsigned operation and flags results that do not fit in 64 bits.

## Interface
- `WID`, 64, operand width; product is 2×`WID`.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset; one clock; asynchronous, active-low (`rst`=0 resets).
- `ld`  in  1  start request; sampled only in IDLE.
- `sgn`  in  1  1 = signed (two's complement), 0 = unsigned.
- `isMuli`  in  1  1 = second operand is `imm`, 0 = `b`.
- `a`  in  64  multiplicand.
- `b`  in  64  register multiplier.
- `imm`  in  64  immediate multiplier.
- `prodLo`  out  64  product bits [63:0], registered.
- `prodHi`  out  64  product bits [127:64], registered.
- `ovf`  out  1  product not representable in 64 bits.
- `done`  out  1  one-cycle pulse; outputs valid.

## Operation
- States: IDLE, MUL, DONE. Reset state IDLE.
- IDLE: on `ld`=1, select op2 = `isMuli` ? `imm` : `b`; capture magnitudes (|`a`|, |op2| if `sgn`, else raw values); `so` = `sgn` & (`a`[63] ^ op2[63]); clear 129-bit accumulator `acc`; load multiplier magnitude into `acc`[63:0]; `cnt` = 64; go MUL.
- MUL, `cnt`≠0: if `acc`[0], `acc`[128:64] += multiplicand magnitude (65-bit sum); then shift `acc` right one; `cnt` decrements.
- MUL, `cnt`=0: result `p` = `so` ? -`acc`[127:0] : `acc`[127:0] (128-bit negate); load `prodHi`/`prodLo`; `ovf` = `sgn` ? (`p`[127:63] not all-equal) : (`p`[127:64]≠0); go DONE.
- DONE: `done`=1; return to IDLE unconditionally.
- Magnitude of -2^63 is 2^63, held unsigned in 64 bits; (-2^63)×(-2^63) = 2^126 is exact.
- `ld` in MUL or DONE is ignored; it is not queued.
- Outputs hold their value from DONE until the next result load or reset.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, `cnt`=0, `acc`=0, `prodLo`=`prodHi`=0, `ovf`=0, `done`=0. Reset mid-operation aborts; no `done` is issued.
- Edge E0 with `ld`=1 in IDLE: operands captured.
- E1..E64: iterations.
- E65: outputs loaded; `done` high for exactly the cycle following E65.
- E66: IDLE.
- Latency is 65 clocks from the accepting edge to `done`. Throughput is one operation per 67 clocks if `ld` is held high, since `ld` is re-accepted at E67.
- Operand inputs are only sampled at E0; changes afterwards do not affect the result.

## Structure
- Shared package `raptor64_pkg`: state encoding (IDLE, MUL, DONE), `WID`, iteration count constant.
- One combinational sub-module, `raptor64_mult_step`: performs the conditional add and right shift on the 129-bit accumulator. The FSM, counter and sign fix-up stay in `raptor64_mult`.

## Test plan
- Unsigned multiply: `sgn`=0, `a`=10005, `b`=27, `ld` pulse.
  - Expected: `done` exactly 65 clocks later.
  - `prodLo`=270135, `prodHi`=0, `ovf`=0.
- Signed multiply with mixed signs: `sgn`=1, `a`=-3, `b`=7.
  - Expected: `prodLo`=0xFFFF_FFFF_FFFF_FFEB, `prodHi`=all ones, `ovf`=0.
- Unsigned overflow: `sgn`=0, `a`=`b`=0xFFFF_FFFF_FFFF_FFFF.
  - Expected: `prodHi`=0xFFFF_FFFF_FFFF_FFFE, `prodLo`=1, `ovf`=1.
  - Same operands with `sgn`=1: `prodLo`=1, `prodHi`=0, `ovf`=0.
- Signed corner case: `sgn`=1, `a`=`b`=0x8000_0000_0000_0000.
  - Expected: `prodHi`=0x4000_0000_0000_0000, `prodLo`=0, `ovf`=1.
- Immediate operand: `isMuli`=1, `a`=123, `b`=5, `imm`=1000.
  - Expected: `prodLo`=123000 (`b` ignored).
  - Hold `ld` high: second `done` arrives 67 clocks after the first.
- Reset mid-operation: assert `rst`=0 at iteration 30.
  - Expected: outputs return to 0 immediately and no `done` is issued.
  - A new `ld` after reset release completes normally.
